// File: rtl/gate_drv_resp.sv
// gate_drv_resp: clocked responder for the buck converter gp/gn gate handshake.
// Drives hs_on/ls_on with dead time before turn-on and after turn-off, holds a
// switch on for a minimum time, and trips to FAULT on a simultaneous gp&gn request.
// Optional macro FAULT_LATCH_EN: FAULT becomes sticky until rst.
//
// state  | meaning
// IDLE   | both switches off, waiting for a synchronised request
// P_DEAD | dead time before high-side turn-on
// P_ON   | high-side on, min-on timer running, gp_ack high
// P_OFF  | high-side off, dead time after turn-off, gp_ack still high
// N_DEAD | dead time before low-side turn-on
// N_ON   | low-side on, min-on timer running, gn_ack high
// N_OFF  | low-side off, dead time after turn-off, gn_ack still high
// FAULT  | simultaneous request seen, everything off, fault high
module gate_drv_resp #(
  parameter int SYNC_STAGES = 2,
  parameter int DEAD_CYC    = 4,
  parameter int MIN_ON_CYC  = 2,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic gp,
  input  logic gn,
  output logic gp_ack,
  output logic gn_ack,
  output logic hs_on,
  output logic ls_on,
  output logic fault
);

  typedef enum logic [2:0] {
    IDLE, P_DEAD, P_ON, P_OFF, N_DEAD, N_ON, N_OFF, FAULT
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LD  = CNT_W'(MIN_ON_CYC - 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_dec;
  logic [SYNC_STAGES-1:0] gp_sync, gn_sync;
  logic rp, rn;

  assign rp      = gp_sync[SYNC_STAGES-1];
  assign rn      = gn_sync[SYNC_STAGES-1];
  assign cnt_dec = (cnt == '0) ? '0 : cnt - CNT_W'(1);

  // Multi-flop synchronisers for the asynchronous request levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gp_sync <= '0;
      gn_sync <= '0;
    end else begin
      gp_sync <= {gp_sync[SYNC_STAGES-2:0], gp};
      gn_sync <= {gn_sync[SYNC_STAGES-2:0], gn};
    end
  end

  // State, shared down-counter and registered outputs decoded from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hs_on  <= 1'b0;
      ls_on  <= 1'b0;
      gp_ack <= 1'b0;
      gn_ack <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hs_on  <= (state_nxt == P_ON);
      ls_on  <= (state_nxt == N_ON);
      gp_ack <= (state_nxt == P_ON) || (state_nxt == P_OFF);
      gn_ack <= (state_nxt == N_ON) || (state_nxt == N_OFF);
      fault  <= (state_nxt == FAULT);
    end
  end

  // Next-state and counter logic; a simultaneous request overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (rp && rn) begin
      state_nxt = FAULT;
      cnt_nxt   = DEAD_LD;
    end else begin
      case (state)
        IDLE: begin
          if (rp) begin
            state_nxt = P_DEAD;
            cnt_nxt   = DEAD_LD;
          end else if (rn) begin
            state_nxt = N_DEAD;
            cnt_nxt   = DEAD_LD;
          end
        end
        P_DEAD: begin
          if (!rp) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            state_nxt = P_ON;
            cnt_nxt   = MIN_LD;
          end else begin
            cnt_nxt = cnt_dec;
          end
        end
        P_ON: begin
          if (cnt != '0) begin
            cnt_nxt = cnt_dec;
          end else if (!rp) begin
            state_nxt = P_OFF;
            cnt_nxt   = DEAD_LD;
          end
        end
        P_OFF: begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt_dec;
        end
        N_DEAD: begin
          if (!rn) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            state_nxt = N_ON;
            cnt_nxt   = MIN_LD;
          end else begin
            cnt_nxt = cnt_dec;
          end
        end
        N_ON: begin
          if (cnt != '0) begin
            cnt_nxt = cnt_dec;
          end else if (!rn) begin
            state_nxt = N_OFF;
            cnt_nxt   = DEAD_LD;
          end
        end
        N_OFF: begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt_dec;
        end
        FAULT: begin
`ifdef FAULT_LATCH_EN
          state_nxt = FAULT;
`else
          // Recover only after DEAD_CYC consecutive cycles with no request.
          if (rp || rn)         cnt_nxt   = DEAD_LD;
          else if (cnt == '0)   state_nxt = IDLE;
          else                  cnt_nxt   = cnt_dec;
`endif
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_drv_resp.sv
// Scoreboard bench for gate_drv_resp: each request pushes its predicted output
// transitions (edge number and level) into per-signal queues; a negedge monitor
// pops and compares every observed transition and checks the safety invariants.
module tb_gate_drv_resp;
  localparam int S = 2;
  localparam int D = 4;
  localparam int M = 2;

  logic clk = 1'b0;
  logic rst, gp, gn;
  logic gp_ack, gn_ack, hs_on, ls_on, fault;

  gate_drv_resp #(.SYNC_STAGES(S), .DEAD_CYC(D), .MIN_ON_CYC(M), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .gp(gp), .gn(gn),
    .gp_ack(gp_ack), .gn_ack(gn_ack), .hs_on(hs_on), .ls_on(ls_on), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_q[5][$];
  bit mon_off = 1'b1;
  int idle_edge = 0;
  int last_fall = -100;
  bit seen_p = 1'b0, seen_n = 1'b0;
  logic [4:0] prev = '0;
  logic [4:0] cur;
  string names[5] = '{"hs_on", "ls_on", "gp_ack", "gn_ack", "fault"};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard comparison of every output transition plus invariants.
  always @(negedge clk) begin
    cur = {fault, gn_ack, gp_ack, ls_on, hs_on};
    if (!mon_off) begin
      for (int i = 0; i < 5; i++) begin
        if (cur[i] != prev[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected change to %0d at edge %0d", names[i], cur[i], cyc);
          end else begin
            int e;
            e = exp_q[i].pop_front();
            if (e != cyc * 2 + int'(cur[i])) begin
              errors++;
              $display("FAIL %s: got level %0d at edge %0d, expected level %0d at edge %0d",
                       names[i], cur[i], cyc, e % 2, e / 2);
            end
          end
        end
      end
      checks++;
      if (hs_on && ls_on) begin
        errors++;
        $display("FAIL overlap: hs_on=1 ls_on=1 at edge %0d, expected not both", cyc);
      end
      seen_p = seen_p | hs_on;
      seen_n = seen_n | ls_on;
      checks++;
      if ((gp_ack && !seen_p) || (gn_ack && !seen_n)) begin
        errors++;
        $display("FAIL ack_before_on: gp_ack=%0d gn_ack=%0d without switch on, edge %0d",
                 gp_ack, gn_ack, cyc);
      end
      if (!gp_ack && !hs_on) seen_p = 1'b0;
      if (!gn_ack && !ls_on) seen_n = 1'b0;
      if ((cur[0] && !prev[0]) || (cur[1] && !prev[1])) begin
        checks++;
        if (cyc - last_fall < D) begin
          errors++;
          $display("FAIL dead_time: got %0d off cycles, expected >= %0d", cyc - last_fall, D);
        end
      end
      if ((!cur[0] && prev[0]) || (!cur[1] && prev[1])) last_fall = cyc;
    end
    prev = cur;
  end

  task automatic go(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int i, input int e, input int v);
    exp_q[i].push_back(e * 2 + v);
  endtask

  task automatic drive(input int side, input logic v);
    if (side == 0) gp = v;
    else           gn = v;
  endtask

  // Reference model of one request: s = edge the FSM starts servicing it,
  // w = first edge at which the released request is seen low.
  task automatic model_req(input int side, input int s, input int w, output int idle);
    int on, hf;
    if (w <= s + D) begin
      idle = w;
    end else begin
      on = s + D;
      push(side, on, 1);
      push(side + 2, on, 1);
      hf = (w > on + M) ? w : on + M;
      push(side, hf, 0);
      push(side + 2, hf + D, 0);
      idle = hf + D;
    end
  endtask

  function automatic int start_edge();
    return ((idle_edge > cyc) ? idle_edge : cyc) + $urandom_range(1, 3);
  endfunction

  task automatic tx_single(input int side, input int len);
    int t0, idle;
    t0 = start_edge();
    go(t0);
    drive(side, 1'b1);
    model_req(side, t0 + S + 1, t0 + len + S + 1, idle);
    go(t0 + len);
    drive(side, 1'b0);
    idle_edge = idle;
  endtask

  task automatic tx_handoff(input int side, input int len, input int k, input int r);
    int t0, idle1, idle2, v2, s2, fall2;
    t0 = start_edge();
    go(t0);
    drive(side, 1'b1);
    model_req(side, t0 + S + 1, t0 + len + S + 1, idle1);
    go(t0 + len);
    drive(side, 1'b0);
    go(t0 + len + k);
    drive(1 - side, 1'b1);
    v2 = cyc + S + 1;
    s2 = (v2 > idle1 + 1) ? v2 : idle1 + 1;
    fall2 = s2 + D + r;
    model_req(1 - side, s2, fall2 + S + 1, idle2);
    go(fall2);
    drive(1 - side, 1'b0);
    idle_edge = idle2;
  endtask

  task automatic reset_seq();
    int left;
    mon_off = 1'b1;
    left = 0;
    for (int i = 0; i < 5; i++) left += exp_q[i].size();
    chk("pending_before_rst", left, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", int'({fault, gn_ack, gp_ack, ls_on, hs_on}), 0);
    gp = 1'b0;
    gn = 1'b0;
    go(cyc + 2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) exp_q[i].delete();
    go(cyc + 3);
    last_fall = cyc;
    seen_p = 1'b0;
    seen_n = 1'b0;
    mon_off = 1'b0;
    idle_edge = cyc;
  endtask

  task automatic tx_fault(input int h);
    int t0, w;
    t0 = start_edge();
    go(t0);
    gp = 1'b1;
    gn = 1'b1;
    push(4, t0 + S + 1, 1);
    go(t0 + h);
    gp = 1'b0;
    gn = 1'b0;
    w = t0 + h + S + 1;
`ifdef FAULT_LATCH_EN
    go(w + 10);
    chk("fault_sticky", int'(fault), 1);
    chk("fault_sticky_sw", int'({hs_on, ls_on}), 0);
    reset_seq();
`else
    push(4, w + D - 1, 0);
    idle_edge = w + D - 1;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    gp = 1'b0;
    gn = 1'b0;
    #1;
    chk("reset_outputs", int'({fault, gn_ack, gp_ack, ls_on, hs_on}), 0);
    go(3);
    rst = 1'b0;
    go(5);
    chk("idle_outputs", int'({fault, gn_ack, gp_ack, ls_on, hs_on}), 0);
    mon_off = 1'b0;
    idle_edge = cyc;

    tx_single(0, 20);
    tx_single(0, 5);
    tx_handoff(0, 8, 1, 5);
    tx_single(0, 2);
    tx_single(1, 12);
    tx_fault(3);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: tx_single(int'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        1: tx_handoff(int'($urandom_range(0, 1)), int'($urandom_range(1, 12)),
                      int'($urandom_range(1, 3)), int'($urandom_range(0, 5)));
        2: tx_fault(int'($urandom_range(1, 6)));
        default: tx_single(int'($urandom_range(0, 1)), int'($urandom_range(1, D)));
      endcase
    end

    go(idle_edge + 6);
    for (int i = 0; i < 5; i++) chk({"drain_", names[i]}, exp_q[i].size(), 0);

    // Async reset while the high side is on.
    mon_off = 1'b1;
    go(cyc + 1);
    gp = 1'b1;
    n = 0;
    while (!hs_on && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_p_on", int'(hs_on), 1);
    chk("reach_p_on_ack", int'(gp_ack), 1);
    reset_seq();
    chk("post_rst_outputs", int'({fault, gn_ack, gp_ack, ls_on, hs_on}), 0);

    tx_single(1, 9);
    go(idle_edge + 6);
    for (int i = 0; i < 5; i++) chk({"final_", names[i]}, exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
